// File: rtl/imem_loader.sv
// Boot loader: receives a big-endian byte stream (16-bit word count, then words)
// and writes each 32-bit word to consecutive instruction-memory addresses, holding the core in reset.
module imem_loader #(
    parameter int DEPTH   = 8192,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_hold_o,
    output logic [15:0] word_count_o
);

    localparam int IDXW = $clog2(DEPTH) + 1;
    localparam int IDLW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_BYTES, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [IDLW-1:0]   idle_q, idle_d;
    logic [15:0]       n_q, n_d;
    logic [23:0]       word_q, word_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              xfer;
    logic [15:0]       n_full;

    // in_ready_q is only ever high in the three receiving states
    assign xfer   = in_ready_q & in_valid_i;
    assign n_full = {n_q[15:8], in_data_i};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bcnt_d      = bcnt_q;
        idle_d      = idle_q;
        n_d         = n_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_HDR_HI;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    idle_d  = '0;
                end
            end
            S_HDR_HI, S_HDR_LO, S_BYTES: begin
                if (xfer) begin
                    idle_d = '0;
                    if (state_q == S_HDR_HI) begin
                        n_d[15:8] = in_data_i;
                        state_d   = S_HDR_LO;
                    end else if (state_q == S_HDR_LO) begin
                        n_d = n_full;
                        if (n_full == 16'd0 || int'(n_full) > DEPTH)
                            state_d = S_ERR;
                        else
                            state_d = S_BYTES;
                    end else begin
                        word_d = {word_q[15:0], in_data_i};
                        bcnt_d = bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            state_d     = S_WRITE;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = 32'(idx_q) << 2;
                            mem_wdata_d = {word_q, in_data_i};
                        end
                    end
                end else if (idle_q == IDLW'(TIMEOUT - 1)) begin
                    // TIMEOUT consecutive idle cycles; any partial word is dropped
                    state_d = S_ERR;
                end else begin
                    idle_d = idle_q + IDLW'(1);
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + IDXW'(1);
                idle_d  = '0;
                state_d = (32'(idx_q) + 32'd1 == 32'(n_q)) ? S_DONE : S_BYTES;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_BYTES);
        busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            bcnt_q      <= '0;
            idle_q      <= '0;
            n_q         <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            idle_q      <= idle_d;
            n_q         <= n_d;
            word_q      <= word_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_hold_q  <= cpu_hold_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign cpu_hold_o   = cpu_hold_q;
    assign word_count_o = n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the stimulus
// thread and checked by an independent monitor on every mem_we.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_we, busy, done, error, cpu_hold;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t expq[$];

    imem_loader #(.DEPTH(8192), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(in_ready), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .busy_o(busy),
        .done_o(done), .error_o(error), .cpu_hold_o(cpu_hold),
        .word_count_o(word_count)
    );

    always #5 clk = ~clk;

    // monitor: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (mem_we) begin
            n_cmp++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = expq.pop_front();
                if (mem_addr !== e.a || mem_wdata !== e.d) begin
                    n_err++;
                    $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                             mem_addr, mem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a; e.d = d;
        expq.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                got = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL send_byte_timeout got=in_ready_low want=transfer");
        end
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]); send_byte(w[23:16]);
        send_byte(w[15:8]);  send_byte(w[7:0]);
    endtask

    task automatic wait_end(input int budget);
        bit got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done || error) begin got = 1; break; end
        end
        @(posedge clk); #1;
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL wait_end_timeout got=none want=done_or_error");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=hung want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w3 [3];
        int gaps [12];
        int g;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_word_count", 32'(word_count), 32'd0);

        // two-word image with exact write/done timing
        pulse_start();
        chk("start_in_ready", 32'(in_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        send_hdr(16'h0002);
        exp_wr(32'h0, 32'h20080005);
        exp_wr(32'h4, 32'h3409000F);
        send_word(32'h20080005);
        chk("w0_we_after_4th", 32'(mem_we), 32'd1);
        chk("w0_ready_low_in_write", 32'(in_ready), 32'd0);
        send_word(32'h3409000F);
        chk("w1_we", 32'(mem_we), 32'd1);
        chk("w1_done_not_yet", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("done_after_write", 32'(done), 32'd1);
        chk("cpu_hold_released", 32'(cpu_hold), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("word_count_2", 32'(word_count), 32'd2);

        // zero-length header
        pulse_start();
        chk("restart_done_clr", {30'd0, done, cpu_hold}, 32'd1);
        send_hdr(16'h0000);
        chk("hdr0_error", 32'(error), 32'd1);
        chk("hdr0_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("hdr0_in_ready", 32'(in_ready), 32'd0);

        // one word past depth
        pulse_start();
        chk("err_clr_on_start", 32'(error), 32'd0);
        send_hdr(16'h2001);
        chk("hdr2001_error", 32'(error), 32'd1);
        chk("hdr2001_wc", 32'(word_count), 32'h2001);

        // full-depth image
        pulse_start();
        send_hdr(16'h2000);
        for (int i = 0; i < 8192; i++) begin
            logic [31:0] d;
            d = {i[15:0], ~i[15:0]};
            exp_wr(32'(i) << 2, d);
            send_word(d);
        end
        wait_end(10);
        chk("full_done", {30'd0, done, error}, 32'd2);
        chk("full_queue_drained", 32'(expq.size()), 32'd0);

        // three words with idle gaps, including the longest legal one
        w3[0] = 32'hDEADBEEF; w3[1] = 32'h01234567; w3[2] = 32'hA5A55A5A;
        gaps = '{0, 3, 1, 1023, 0, 7, 2, 0, 15, 1, 0, 5};
        pulse_start();
        send_hdr(16'h0003);
        pulse_start();
        chk("start_ignored_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) exp_wr(32'(i) << 2, w3[i]);
        for (int j = 0; j < 12; j++) begin
            g = gaps[j];
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            send_byte(w3[j/4][31 - 8*(j%4) -: 8]);
        end
        wait_end(10);
        chk("gaps_done", {30'd0, done, error}, 32'd2);
        chk("gaps_wc", 32'(word_count), 32'd3);

        // stall mid-word until timeout
        pulse_start();
        send_hdr(16'h0002);
        exp_wr(32'h0, 32'h13572468);
        send_word(32'h13572468);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (1023) @(posedge clk);
        #1;
        chk("stall_no_err_yet", 32'(error), 32'd0);
        @(posedge clk); #1;
        chk("stall_error", 32'(error), 32'd1);
        chk("stall_hold_busy", {30'd0, cpu_hold, busy}, 32'd2);
        pulse_start();
        chk("stall_err_clr", 32'(error), 32'd0);
        send_hdr(16'h0001);
        exp_wr(32'h0, 32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        wait_end(10);
        chk("recover_done", {30'd0, done, error}, 32'd2);

        // asynchronous reset after the 6th payload byte
        pulse_start();
        send_hdr(16'h0002);
        exp_wr(32'h0, 32'h11223344);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_status", {28'd0, in_ready, busy, done, error}, 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd1);
        chk("arst_wc", 32'(word_count), 32'd0);
        chk("arst_addr_data", mem_addr | mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        send_hdr(16'h0001);
        exp_wr(32'h0, 32'h0BADC0DE);
        send_word(32'h0BADC0DE);
        wait_end(10);
        chk("post_rst_done", {30'd0, done, error}, 32'd2);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
